// File: rtl/shift_sequencer.sv
// Command sequencer for an N-bit universal shift register: one command per handshake, result returned on rsp_*.
// Build option: define SHSEQ_PRELOAD_EN to honour cmd_load (one LOAD cycle before a shift).
module shift_sequencer #(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [N-1:0]  cmd_data,
    input  logic [CW-1:0] cmd_count,
    input  logic          cmd_fill,
    input  logic          cmd_load,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [N-1:0]  rsp_data,
    output logic          busy,
    output logic [2:0]    sr_S,
    output logic [N-1:0]  sr_D,
    output logic          sr_MSBin,
    output logic          sr_LSBin,
    input  logic [N-1:0]  sr_Q
);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_LSR  = 3'd2;
    localparam logic [2:0] OP_LSL  = 3'd3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SHIFT  = 3'd2,
        SETTLE = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [N-1:0]  data_q, data_d;
    logic          fill_q, fill_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          cmd_ready_d, rsp_valid_d, busy_d;
    logic [N-1:0]  rsp_data_d, sr_D_d;
    logic [2:0]    sr_S_d;
    logic          sr_MSBin_d, sr_LSBin_d;

    logic [CW-1:0] eff_count_c;
    logic          preload_c;

    assign eff_count_c = (cmd_count > CW'(N)) ? CW'(N) : cmd_count;

`ifdef SHSEQ_PRELOAD_EN
    assign preload_c = cmd_load;
`else
    logic unused_load_c;
    assign unused_load_c = cmd_load;
    assign preload_c     = 1'b0;
`endif

    // State and registered outputs
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q   <= IDLE;
            op_q      <= OP_NOP;
            data_q    <= '0;
            fill_q    <= 1'b0;
            cnt_q     <= '0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            busy      <= 1'b0;
            sr_S      <= OP_NOP;
            sr_D      <= '0;
            sr_MSBin  <= 1'b0;
            sr_LSBin  <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            data_q    <= data_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
            cmd_ready <= cmd_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            busy      <= busy_d;
            sr_S      <= sr_S_d;
            sr_D      <= sr_D_d;
            sr_MSBin  <= sr_MSBin_d;
            sr_LSBin  <= sr_LSBin_d;
        end
    end

    // Next state; the final SHIFT cycle (counter at zero) drives NOP, giving count+2 latency
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        data_d      = data_q;
        fill_d      = fill_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid;
        rsp_data_d  = rsp_data;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d   = cmd_op;
                    data_d = cmd_data;
                    fill_d = cmd_fill;
                    cnt_d  = eff_count_c;
                    if (cmd_op == OP_NOP)
                        state_d = SETTLE;
                    else if (cmd_op == OP_LOAD || preload_c)
                        state_d = LOAD;
                    else
                        state_d = SHIFT;
                end
            end
            LOAD:   state_d = (op_q == OP_LOAD) ? SETTLE : SHIFT;
            SHIFT: begin
                if (cnt_q == '0)
                    state_d = SETTLE;
                else
                    cnt_d = cnt_q - CW'(1);
            end
            SETTLE: begin
                rsp_data_d  = sr_Q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Register-side outputs follow the state being entered
        cmd_ready_d = (state_q == IDLE) && (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        sr_S_d      = OP_NOP;
        sr_D_d      = '0;
        sr_MSBin_d  = 1'b0;
        sr_LSBin_d  = 1'b0;
        if (state_d == LOAD) begin
            sr_S_d = OP_LOAD;
            sr_D_d = data_d;
        end else if (state_d == SHIFT && cnt_d != '0) begin
            sr_S_d     = op_d;
            sr_MSBin_d = (op_d == OP_LSR) && fill_d;
            sr_LSBin_d = (op_d == OP_LSL) && fill_d;
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer with a behavioural universal shift register on sr_*.
module tb_shift_sequencer;

    localparam int N  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          clear = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = 3'd0;
    logic [N-1:0]  cmd_data = '0;
    logic [CW-1:0] cmd_count = '0;
    logic          cmd_fill = 1'b0;
    logic          cmd_load = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [N-1:0]  rsp_data;
    logic          busy;
    logic [2:0]    sr_S;
    logic [N-1:0]  sr_D;
    logic          sr_MSBin, sr_LSBin;
    logic [N-1:0]  sr_q = '0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]    op;
        logic [N-1:0]  data;
        logic [CW-1:0] count;
        logic          fill;
        logic          load;
        logic [N-1:0]  exp_data;
        int            exp_lat;
        int            exp_act;
        int            hold;
    } vec_t;

    typedef struct {
        logic [N-1:0] data;
        int           lat;
        int           act;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[13];

    always #5 clk = ~clk;

    shift_sequencer #(.N(N), .CW(CW)) dut (
        .clk(clk), .clear(clear),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_count(cmd_count), .cmd_fill(cmd_fill), .cmd_load(cmd_load),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy),
        .sr_S(sr_S), .sr_D(sr_D), .sr_MSBin(sr_MSBin), .sr_LSBin(sr_LSBin), .sr_Q(sr_q)
    );

    // Universal shift register driven by the sequencer; not touched by clear
    always @(posedge clk) begin
        case (sr_S)
            3'd1: sr_q <= sr_D;
            3'd2: sr_q <= {sr_MSBin, sr_q[N-1:1]};
            3'd3: sr_q <= {sr_q[N-2:0], sr_LSBin};
            3'd4: sr_q <= {sr_q[0], sr_q[N-1:1]};
            3'd5: sr_q <= {sr_q[N-2:0], sr_q[N-1]};
            3'd6: sr_q <= {sr_q[N-1], sr_q[N-1:1]};
            3'd7: sr_q <= {sr_q[N-2:0], 1'b0};
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Wait for cmd_ready, drive one command through its accept edge; returns at the next negedge
    task automatic issue(input vec_t v, output bit ok);
        int w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        ok = cmd_ready;
        if (!ok) begin
            check("issue_ready", 32'(cmd_ready), 1);
            return;
        end
        cmd_op    = v.op;
        cmd_data  = v.data;
        cmd_count = v.count;
        cmd_fill  = v.fill;
        cmd_load  = v.load;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_data  = 8'($urandom);
        cmd_count = 4'($urandom);
    endtask

    task automatic run(input vec_t v, input string name);
        bit ok;
        int lat, act, serbad, bad;
        exp_t e;
        logic [N-1:0] held;
        issue(v, ok);
        if (!ok) return;
        sb.push_back(exp_t'{v.exp_data, v.exp_lat, v.exp_act});
        lat = 0; act = 0; serbad = 0;
        while (lat < 40) begin
            if (sr_S != 3'd0) act++;
            if (sr_MSBin !== ((sr_S == 3'd2) ? v.fill : 1'b0)) serbad++;
            if (sr_LSBin !== ((sr_S == 3'd3) ? v.fill : 1'b0)) serbad++;
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (rsp_valid) break;
        end
        if (rsp_valid !== 1'b1) begin
            check({name, "_rsp_timeout"}, 32'(rsp_valid), 1);
            sb.delete();
            return;
        end
        e = sb.pop_front();
        check({name, "_latency"}, 32'(lat), 32'(e.lat));
        check({name, "_shift_cycles"}, 32'(act), 32'(e.act));
        check({name, "_rsp_data"}, 32'(rsp_data), 32'(e.data));
        check({name, "_serial_in"}, 32'(serbad), 0);
        if (v.hold > 0) begin
            bad  = 0;
            held = rsp_data;
            for (int h = 0; h < v.hold; h++) begin
                @(posedge clk);
                @(negedge clk);
                if (rsp_valid !== 1'b1 || rsp_data !== held || cmd_ready !== 1'b0 ||
                    sr_S !== 3'd0 || busy !== 1'b1) bad++;
            end
            check({name, "_backpressure"}, 32'(bad), 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check({name, "_rsp_drop"}, 32'(rsp_valid), 0);
        check({name, "_ready_gap"}, 32'(cmd_ready), 0);
        @(negedge clk);
        check({name, "_ready_back"}, 32'(cmd_ready), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rr, ld, rb;
        bit ok;

        //          op    data   cnt  fill  load  exp    lat act hold
        vecs[0]  = '{3'd1, 8'h0F, 4'd0,  1'b0, 1'b0, 8'h0F, 2,  1,  0};
`ifdef SHSEQ_PRELOAD_EN
        vecs[1]  = '{3'd2, 8'h61, 4'd3,  1'b1, 1'b1, 8'hEC, 6,  4,  0};
`else
        vecs[1]  = '{3'd2, 8'h61, 4'd3,  1'b1, 1'b1, 8'hE1, 5,  3,  0};
`endif
        vecs[2]  = '{3'd1, 8'hB3, 4'd0,  1'b0, 1'b0, 8'hB3, 2,  1,  0};
        vecs[3]  = '{3'd6, 8'h00, 4'd3,  1'b0, 1'b0, 8'hF6, 5,  3,  0};
        vecs[4]  = '{3'd1, 8'h1B, 4'd0,  1'b0, 1'b0, 8'h1B, 2,  1,  0};
        vecs[5]  = '{3'd4, 8'h00, 4'd8,  1'b0, 1'b0, 8'h1B, 10, 8,  0};
        vecs[6]  = '{3'd5, 8'h00, 4'd12, 1'b0, 1'b0, 8'h1B, 10, 8,  0};
        vecs[7]  = '{3'd1, 8'h2D, 4'd0,  1'b0, 1'b0, 8'h2D, 2,  1,  0};
        vecs[8]  = '{3'd7, 8'h00, 4'd2,  1'b0, 1'b0, 8'hB4, 4,  2,  4};
        vecs[9]  = '{3'd3, 8'hFF, 4'd0,  1'b1, 1'b0, 8'hB4, 2,  0,  0};
        vecs[10] = '{3'd0, 8'hFF, 4'd5,  1'b1, 1'b0, 8'hB4, 1,  0,  0};
        vecs[11] = '{3'd3, 8'h00, 4'd2,  1'b1, 1'b0, 8'hD3, 4,  2,  0};
        vecs[12] = '{3'd2, 8'h00, 4'd15, 1'b0, 1'b0, 8'h00, 10, 8,  0};

        // Reset state
        #1 clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_sr_S", 32'(sr_S), 0);
        check("rst_sr_D", 32'(sr_D), 0);
        check("rst_serial", 32'({sr_MSBin, sr_LSBin}), 0);
        clear = 1'b0;
        @(negedge clk);
        check("idle_cmd_ready", 32'(cmd_ready), 1);

        for (int i = 0; i < 13; i++)
            run(vecs[i], $sformatf("v%0d", i));

        // Clear during the second cycle of an 8-cycle rotate right
        ld = '{3'd1, 8'h96, 4'd0, 1'b0, 1'b0, 8'h96, 2, 1, 0};
        run(ld, "ld96");
        rr = '{3'd4, 8'h00, 4'd8, 1'b0, 1'b0, 8'h00, 10, 8, 0};
        issue(rr, ok);
        check("rr_cycle1", 32'(sr_S), 4);
        @(posedge clk);
        @(negedge clk);
        check("rr_cycle2", 32'(sr_S), 4);
        clear = 1'b1;
        #1;
        check("clr_sr_S", 32'(sr_S), 0);
        check("clr_rsp_valid", 32'(rsp_valid), 0);
        check("clr_busy", 32'(busy), 0);
        check("clr_cmd_ready", 32'(cmd_ready), 0);
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        check("clr_ready_after", 32'(cmd_ready), 1);
        rb = '{3'd0, 8'h00, 4'd0, 1'b0, 1'b0, 8'h4B, 1, 0, 0};
        run(rb, "readback_after_clear");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
